// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick scheduler: tick-source select codes,
// FSM state encoding and the round-robin pointer wrap helper.
package tick_sched_pkg;

   localparam logic [1:0] SEL_ODD  = 2'd0;
   localparam logic [1:0] SEL_EVEN = 2'd1;
   localparam logic [1:0] SEL_02   = 2'd2;
   localparam logic [1:0] SEL_19   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int wrap_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping around, returned both one-hot and as an index.
module rr_arbiter #(
   parameter int  NREQ  = 4,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx
);

   // Scan from farthest to nearest so the request closest to rr_ptr wins.
   always_comb begin
      int unsigned j;
      j   = 0;
      gnt = '0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/tick_sched.sv
// Shared countdown timer: grants one requester at a time round-robin, counts
// that owner's chosen tick source and pulses done when the interval expires.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int  NREQ  = 4,
   parameter int  CNT_W = 8,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tick_odd_sec,
   input  logic                  tick_even_sec,
   input  logic                  tick_even_02sec,
   input  logic                  tick_19,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     req_sel,
   input  logic [CNT_W*NREQ-1:0] req_cnt,
   input  logic [NREQ-1:0]       cancel,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [IDX_W-1:0]      owner
);

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             busy_q, busy_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;

   logic [NREQ-1:0]  win_gnt;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] next_ptr;
   logic             tick_hit;

   logic [1:0]       sel_arr [NREQ];
   logic [CNT_W-1:0] cnt_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign sel_arr[gi] = req_sel[2*gi +: 2];
      assign cnt_arr[gi] = req_cnt[CNT_W*gi +: CNT_W];
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .gnt    (win_gnt),
      .idx    (win_idx)
   );

   assign next_ptr = IDX_W'(wrap_next(int'(owner_q), NREQ));

   always_comb begin
      tick_hit = 1'b0;
      case (sel_q)
         SEL_ODD:  tick_hit = tick_odd_sec;
         SEL_EVEN: tick_hit = tick_even_sec;
         SEL_02:   tick_hit = tick_even_02sec;
         SEL_19:   tick_hit = tick_19;
         default:  tick_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = '0;
      done_d      = '0;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      sel_d       = sel_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d     = win_gnt;
               owner_d     = win_idx;
               sel_d       = sel_arr[win_idx];
               remaining_d = cnt_arr[win_idx];
               state_d     = (cnt_arr[win_idx] == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Cancel outranks a coinciding final tick.
            if (cancel[owner_q]) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end else if (tick_hit) begin
               if (remaining_q > CNT_W'(1)) begin
                  remaining_d = remaining_q - CNT_W'(1);
               end else begin
                  state_d         = ST_DONE;
                  done_d[owner_q] = 1'b1;
               end
            end
         end
         ST_DONE: begin
            // A zero-count grant arrives here without a done pulse yet; emit it first.
            if (done_q == '0) begin
               done_d[owner_q] = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         sel_q       <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         sel_q       <= sel_d;
         remaining_q <= remaining_d;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed scenarios plus randomized requester/tick traffic for tick_sched,
// checked every cycle against a transaction-level scheduler model.
module tb_tick_sched;

   localparam int NREQ  = 4;
   localparam int CNT_W = 8;
   localparam int IDX_W = 2;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  tick_odd_sec = 1'b0;
   logic                  tick_even_sec = 1'b0;
   logic                  tick_even_02sec = 1'b0;
   logic                  tick_19 = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [2*NREQ-1:0]     req_sel = '0;
   logic [CNT_W*NREQ-1:0] req_cnt = '0;
   logic [NREQ-1:0]       cancel = '0;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [IDX_W-1:0]      owner;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   tick_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .tick_odd_sec    (tick_odd_sec),
      .tick_even_sec   (tick_even_sec),
      .tick_even_02sec (tick_even_02sec),
      .tick_19         (tick_19),
      .req             (req),
      .req_sel         (req_sel),
      .req_cnt         (req_cnt),
      .cancel          (cancel),
      .grant           (grant),
      .done            (done),
      .busy            (busy),
      .owner           (owner)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Scheduler model. phase: 0 free, 1 counting ticks, 2 done shown (releasing),
   // 3 zero-count job whose done is due next cycle.
   int              m_phase = 0;
   int              m_owner = 0;
   int              m_ptr   = 0;
   int              m_left  = 0;
   int              m_sel   = 0;
   int              m_w     = 0;
   logic [3:0]      m_tv;
   logic [NREQ-1:0] m_grant = '0;
   logic [NREQ-1:0] m_done  = '0;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_phase = 0; m_owner = 0; m_ptr = 0; m_left = 0; m_sel = 0;
         m_grant = '0; m_done = '0;
      end else begin
         m_grant = '0;
         m_done  = '0;
         m_tv    = {tick_19, tick_even_02sec, tick_even_sec, tick_odd_sec};
         case (m_phase)
            0: begin
               m_w = pick(req, m_ptr);
               if (m_w >= 0) begin
                  m_grant[m_w] = 1'b1;
                  m_owner = m_w;
                  m_sel   = int'(req_sel[2*m_w +: 2]);
                  m_left  = int'(req_cnt[CNT_W*m_w +: CNT_W]);
                  m_phase = (m_left == 0) ? 3 : 1;
               end
            end
            1: begin
               if (cancel[m_owner]) begin
                  m_phase = 0;
                  m_ptr   = (m_owner + 1) % NREQ;
               end else if (m_tv[m_sel]) begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_done[m_owner] = 1'b1;
                     m_phase = 2;
                  end
               end
            end
            2: begin
               m_phase = 0;
               m_ptr   = (m_owner + 1) % NREQ;
            end
            default: begin
               m_done[m_owner] = 1'b1;
               m_phase = 2;
            end
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("grant", int'(grant), int'(m_grant));
         check("done",  int'(done),  int'(m_done));
         check("busy",  int'(busy),  (m_phase != 0) ? 1 : 0);
         check("owner", int'(owner), m_owner);
      end
   end

   int              order[$];
   int              exp_order[5] = '{0, 1, 2, 3, 0};
   int              ndone;
   bit              re0;
   logic [NREQ-1:0] fresh;

   initial begin
      // Reset state
      step(3);
      check("rst_grant", int'(grant), 0);
      check("rst_done",  int'(done),  0);
      check("rst_busy",  int'(busy),  0);
      check("rst_owner", int'(owner), 0);
      chk_en  = 1'b1;
      reset_n = 1'b1;
      step(2);

      // 1: single request, three odd-second ticks
      req = 4'b0001; req_sel[1:0] = 2'd0; req_cnt[7:0] = 8'd3;
      step(1);
      $display("t1 grant=%b", grant);
      check("t1_grant", int'(grant), 4'b0001);
      req = '0;
      for (int p = 1; p <= 3; p++) begin
         step(4);
         tick_odd_sec = 1'b1;
         step(1);
         tick_odd_sec = 1'b0;
         check("t1_done", int'(done), (p == 3) ? 1 : 0);
      end
      check("t1_busy_at_done", int'(busy), 1);
      step(1);
      check("t1_busy_after", int'(busy), 0);
      check("t1_done_single", int'(done), 0);

      // 2: round-robin from a fresh pointer
      #2 reset_n = 1'b0;
      step(2);
      #2 reset_n = 1'b1;
      step(1);
      req_sel = 8'hFF;
      req_cnt = {4{8'd1}};
      req     = 4'b1111;
      ndone = 0; re0 = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick_19 = (c % 10 == 5);
         step(1);
         tick_19 = 1'b0;
         if (grant != '0) begin
            order.push_back(oh_idx(grant));
            $display("t2 grant idx=%0d", oh_idx(grant));
            req = req & ~grant;
            if (grant[0] && !re0) begin
               re0    = 1'b1;
               req[0] = 1'b1;
            end
         end
         if (done != '0) ndone++;
      end
      check("t2_ngrants", order.size(), 5);
      for (int i = 0; i < order.size() && i < 5; i++)
         check("t2_order", order[i], exp_order[i]);
      check("t2_ndone", ndone, 5);

      // 3: zero count
      req = 4'b0100; req_cnt[23:16] = 8'd0;
      step(1);
      check("t3_grant", int'(grant), 4'b0100);
      req = '0;
      step(1);
      check("t3_done", int'(done), 4'b0100);
      check("t3_grant_gone", int'(grant), 0);
      step(1);
      check("t3_busy", int'(busy), 0);

      // 4: tick filtering, even-second source
      req = 4'b0010; req_sel[3:2] = 2'd1; req_cnt[15:8] = 8'd2;
      step(1);
      check("t4_grant", int'(grant), 4'b0010);
      req = '0;
      for (int i = 0; i < 8; i++) begin
         {tick_19, tick_even_02sec, tick_odd_sec} = 3'($urandom_range(1, 7));
         step(1);
         {tick_19, tick_even_02sec, tick_odd_sec} = 3'b000;
         check("t4_filtered", int'(done), 0);
      end
      tick_even_sec = 1'b1;
      step(1);
      tick_even_sec = 1'b0;
      check("t4_first_even", int'(done), 0);
      step(2);
      tick_even_sec = 1'b1;
      step(1);
      tick_even_sec = 1'b0;
      check("t4_done", int'(done), 4'b0010);

      // 5: cancel from non-owner ignored; owner cancel beats final tick
      step(2);
      req = 4'b0010; req_sel[3:2] = 2'd0; req_cnt[15:8] = 8'd2;
      step(1);
      check("t5_grant", int'(grant), 4'b0010);
      req = '0;
      tick_odd_sec = 1'b1;
      step(1);
      tick_odd_sec = 1'b0;
      cancel = 4'b1000;
      step(1);
      cancel = '0;
      check("t5_foreign_cancel", int'(busy), 1);
      tick_odd_sec = 1'b1;
      cancel = 4'b0010;
      step(1);
      tick_odd_sec = 1'b0;
      cancel = '0;
      check("t5_cancel_done", int'(done), 0);
      check("t5_cancel_busy", int'(busy), 0);
      step(1);
      check("t5_no_late_done", int'(done), 0);

      // 6: asynchronous reset mid-run with remaining=5
      req = 4'b1000; req_sel[7:6] = 2'd2; req_cnt[31:24] = 8'd8;
      step(1);
      check("t6_grant", int'(grant), 4'b1000);
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick_even_02sec = 1'b1;
         step(1);
         tick_even_02sec = 1'b0;
         step(1);
      end
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_grant", int'(grant), 0);
      check("t6_rst_done",  int'(done),  0);
      check("t6_rst_busy",  int'(busy),  0);
      check("t6_rst_owner", int'(owner), 0);
      step(2);
      #2 reset_n = 1'b1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         tick_even_02sec = 1'b1;
         step(1);
         tick_even_02sec = 1'b0;
         check("t6_quiet", int'(grant | done), 0);
      end
      req = 4'b0010; req_cnt[15:8] = 8'd1;
      step(1);
      check("t6_new_grant", int'(grant), 4'b0010);
      req = '0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         req = req & ~grant;
         fresh = '0;
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && !grant[i] && $urandom_range(0, 7) == 0) fresh[i] = 1'b1;
         req     = req | fresh;
         req_sel = 8'($urandom);
         for (int i = 0; i < NREQ; i++)
            req_cnt[CNT_W*i +: CNT_W] = CNT_W'($urandom_range(0, 5));
         tick_odd_sec    = ($urandom_range(0, 4) == 0);
         tick_even_sec   = ($urandom_range(0, 4) == 0);
         tick_even_02sec = ($urandom_range(0, 4) == 0);
         tick_19         = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < NREQ; i++)
            cancel[i] = ($urandom_range(0, 15) == 0);
         step(1);
      end
      req = '0; cancel = '0;
      {tick_odd_sec, tick_even_sec, tick_even_02sec, tick_19} = 4'b0000;
      step(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
